// File: rtl/reg_file_wb_arbiter.sv
// Round-robin write-back arbiter for the reg_file write port.
// One grant per cycle, registered into a single output stage.
module reg_file_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] req_reg,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
  output logic [NUM_SRC-1:0]            req_ready,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_reg,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IDX_W-1:0]              grant_idx
);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      cand;
  logic                  found;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  int unsigned           j;

  // Scan from rr_ptr with wrap; first valid source wins. Reset blocks grants.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j    = (int'(rr_ptr) + k) % NUM_SRC;
      cand = IDX_W'(j);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst_n) found = 1'b0;
    req_ready = found ? (NUM_SRC'(1) << gnt_idx) : '0;
    sel_reg   = req_reg[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Advance pointer past the winner; x0 targets complete but never write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      grant_idx <= '0;
    end else begin
      wr_en <= found && (sel_reg != '0);
      if (found) begin
        rr_ptr <= (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (found && (sel_reg != '0)) begin
        wr_reg    <= sel_reg;
        wr_data   <= sel_data;
        grant_idx <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Table-driven bench for reg_file_wb_arbiter with a reg_file model.
// Inputs driven #1 after posedge, outputs sampled #1 later.
module tb_reg_file_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [1:0]  grant_idx;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];

  typedef struct {
    logic [2:0]  v;
    logic [14:0] r;
    logic [95:0] d;
    logic [2:0]  rdy;
    logic        en;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  gi;
  } vec_t;

  vec_t vecs [12];

  reg_file_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  // reg_file model: x0 hardwired, no commits while in reset
  always @(posedge clk) begin
    if (rst_n && wr_en && wr_reg != 5'd0) rf[wr_reg] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int n);
    req_valid = t.v;
    req_reg   = t.r;
    req_data  = t.d;
    #1;
    chk($sformatf("v%0d ready", n), 32'(req_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d wr_en", n), 32'(wr_en), 32'(t.en));
    chk($sformatf("v%0d wr_reg", n), 32'(wr_reg), 32'(t.wreg));
    chk($sformatf("v%0d wr_data", n), wr_data, t.wdata);
    chk($sformatf("v%0d grant_idx", n), 32'(grant_idx), 32'(t.gi));
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : rf[a];
    chk($sformatf("read x%0d", a), v, exp);
  endtask

  initial begin
    vec_t t;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    vecs[0]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0002,32'h0001,32'h0000},
                 3'b001, 1'b1, 5'd1, 32'h0000, 2'd0};
    vecs[1]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0102,32'h0101,32'h0100},
                 3'b010, 1'b1, 5'd2, 32'h0101, 2'd1};
    vecs[2]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0202,32'h0201,32'h0200},
                 3'b100, 1'b1, 5'd3, 32'h0202, 2'd2};
    vecs[3]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0302,32'h0301,32'h0300},
                 3'b001, 1'b1, 5'd1, 32'h0300, 2'd0};
    vecs[4]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0402,32'h0401,32'h0400},
                 3'b010, 1'b1, 5'd2, 32'h0401, 2'd1};
    vecs[5]  = '{3'b111, {5'd3,5'd2,5'd1}, {32'h0502,32'h0501,32'h0500},
                 3'b100, 1'b1, 5'd3, 32'h0502, 2'd2};
    vecs[6]  = '{3'b010, {5'd0,5'd5,5'd0}, {32'h0,32'hDEADBEEF,32'h0},
                 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1};
    vecs[7]  = '{3'b000, 15'd0, 96'd0,
                 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1};
    vecs[8]  = '{3'b100, 15'd0, {32'h12345678,32'h0,32'h0},
                 3'b100, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1};
    vecs[9]  = '{3'b011, {5'd0,5'd7,5'd7}, {32'h0,32'h5555FFFF,32'hAAAA0000},
                 3'b001, 1'b1, 5'd7, 32'hAAAA0000, 2'd0};
    vecs[10] = '{3'b010, {5'd0,5'd7,5'd7}, {32'h0,32'h5555FFFF,32'hAAAA0000},
                 3'b010, 1'b1, 5'd7, 32'h5555FFFF, 2'd1};
    vecs[11] = '{3'b000, 15'd0, 96'd0,
                 3'b000, 1'b0, 5'd7, 32'h5555FFFF, 2'd1};

    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_reg   = {5'd3,5'd2,5'd1};
    req_data  = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("rst%0d ready", c), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d wr_en", c), 32'(wr_en), 32'd0);
    end
    chk("rst wr_reg", 32'(wr_reg), 32'd0);
    chk("rst wr_data", wr_data, 32'd0);
    chk("rst grant_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(vecs[i], i);

    rd(5'd1, 32'h0300);
    rd(5'd2, 32'h0401);
    rd(5'd3, 32'h0502);
    rd(5'd5, 32'hDEADBEEF);
    rd(5'd7, 32'h5555FFFF);
    rd(5'd0, 32'h0);

    // reset lands while x9 write sits in the output stage (rr_ptr=2 here)
    t = '{3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h1},
          3'b001, 1'b1, 5'd9, 32'h1, 2'd0};
    step(t, 12);
    rst_n     = 1'b0;
    req_valid = 3'b010;
    #1;
    chk("midrst ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst wr_en", 32'(wr_en), 32'd0);
    chk("midrst wr_reg", 32'(wr_reg), 32'd0);
    rst_n = 1'b1;
    rd(5'd9, 32'h0);

    // 101 separates rr_ptr=0 (grants 0) from a stale rr_ptr=1 (grants 2)
    t = '{3'b101, {5'd11,5'd0,5'd10}, {32'h22,32'h0,32'h10},
          3'b001, 1'b1, 5'd10, 32'h10, 2'd0};
    step(t, 13);
    t = '{3'b100, {5'd11,5'd0,5'd10}, {32'h22,32'h0,32'h10},
          3'b100, 1'b1, 5'd11, 32'h22, 2'd2};
    step(t, 14);
    t = '{3'b000, 15'd0, 96'd0,
          3'b000, 1'b0, 5'd11, 32'h22, 2'd2};
    step(t, 15);
    rd(5'd10, 32'h10);
    rd(5'd11, 32'h22);
    rd(5'd9, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_wb_arbiter.md
# reg_file_wb_arbiter

Round-robin write-back arbiter that shares the single write port of `reg_file` among `NUM_SRC` producers (e.g. ALU, load unit, multi-cycle mul/div). Each producer presents a valid/ready request carrying a destination register and data. The arbiter grants at most one request per cycle and registers the winner into a one-stage output that drives `reg_file` `wr_en`/`wr_reg`/`wr_data` directly. It sits between the execute/memory stages and `reg_file`, and is the only block allowed to drive the register file write port.

## Interface
- `NUM_SRC`, default 3: number of requesters; legal range 2..8.
- `DATA_WIDTH`, default 32: register data width.
- `ADDR_WIDTH`, default 5: register index width (32 registers, x0 hardwired zero).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req_valid` input `NUM_SRC`: per-source request valid.
- `req_reg` input `NUM_SRC*ADDR_WIDTH`: per-source destination register; source i occupies bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data` input `NUM_SRC*DATA_WIDTH`: per-source write data, packed the same way.
- `req_ready` output `NUM_SRC`: per-source grant. One-hot or zero. The handshake completes on a cycle where `valid & ready`.
- `wr_en` output 1: to `reg_file` `wr_en`.
- `wr_reg` output `ADDR_WIDTH`: to `reg_file` `wr_reg`.
- `wr_data` output `DATA_WIDTH`: to `reg_file` `wr_data`.
- `grant_idx` output `$clog2(NUM_SRC)`: index of the source whose write is currently on `wr_*`. Valid when `wr_en`=1; debug and coverage only.

## Operation
- **State**
  - `rr_ptr`: index of the highest-priority source, range 0..`NUM_SRC`-1.
  - Output stage registers: `wr_en`, `wr_reg`, `wr_data`, `grant_idx`.
- **Arbitration (combinational, each cycle)**
  - Scan sources starting at `rr_ptr` and wrap modulo `NUM_SRC`.
  - The first source with `req_valid`=1 wins; its `req_ready` is set to 1 and all other `req_ready` bits are 0.
  - If no source is valid, `req_ready`=0.
- **Pointer update**
  - On a grant to source g: `rr_ptr <= (g+1) mod NUM_SRC`.
  - With no grant, `rr_ptr` holds its value.
  - Wrap: a grant to source `NUM_SRC`-1 sets `rr_ptr` to 0.
- **Output stage**
  - The output stage drains every cycle, so `req_ready` never waits on downstream state.
  - On a grant to source g with `req_reg[g]` != 0: `wr_en<=1`, `wr_reg<=req_reg[g]`, `wr_data<=req_data[g]`, `grant_idx<=g`.
  - On a grant whose `req_reg` = 0 (x0): the handshake completes and the pointer advances, but `wr_en<=0`. The write is silently dropped, and `wr_reg`/`wr_data`/`grant_idx` hold their previous values.
  - With no grant: `wr_en<=0`, and the other output registers hold.
- **Requester protocol**
  - Once `req_valid` is asserted, the source holds it and keeps `req_reg`/`req_data` stable until the handshake completes.
  - The arbiter need not tolerate withdrawal; the bench flags withdrawal as a protocol violation.
- **Same-destination conflicts**: two sources targeting the same register are written in grant order. The later grant's data is the final register contents.
- **Fairness**: with all sources continuously valid, each source is granted exactly once in every `NUM_SRC` consecutive cycles. Maximum wait from `req_valid` rising to grant is `NUM_SRC`-1 cycles.

## Timing
- **Reset values** while `rst_n`=0 at a rising edge: `rr_ptr`=0, `wr_en`=0, `wr_reg`=0, `wr_data`=0, `grant_idx`=0.
  - `req_ready` is forced to all zeros during any cycle in which `rst_n`=0.
- **Reset mid-operation**
  - A request presented in a reset cycle is not granted.
  - A write sitting in the output stage is discarded: `wr_en` goes to 0 on that edge, so no write reaches `reg_file`.
- **Latency**
  - Handshake at edge N (valid & ready sampled) → `wr_en`/`wr_reg`/`wr_data` valid during cycle N..N+1.
  - `reg_file` commits at edge N+1.
  - The write data is visible on `reg_file` combinational reads after edge N+1.
  - Total request-to-architectural-visibility is 2 edges.
- **Throughput**: one write per cycle, with no bubbles between back-to-back grants.
- **Combinational paths**
  - `req_ready` depends combinationally on `req_valid`, `rst_n` and `rr_ptr`.
  - No combinational path exists from `req_*` to `wr_*`.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles with all `req_valid`=1 → `req_ready`=000 and `wr_en`=0. After release, the first grant goes to source 0 (`rr_ptr`=0).
- **Single source**: source 1 writes x5=0xDEADBEEF → `req_ready`=010 for one cycle. Next cycle `wr_en`=1, `wr_reg`=5, `wr_data`=0xDEADBEEF, `grant_idx`=1. A `reg_file` read of x5 then returns 0xDEADBEEF.
- **Full contention**: all 3 sources valid for 6 cycles with distinct targets x1/x2/x3 → grant order 0,1,2,0,1,2. `wr_en`=1 on 6 consecutive cycles; the pointer wraps from 2 to 0.
- **x0 suppression**: source 2 writes x0=0x12345678 → `req_ready[2]`=1 and `rr_ptr` becomes 0. `wr_en` stays 0, and a read of x0 returns 0.
- **Same-register conflict**, `rr_ptr`=0:
  - Sources 0 and 1 both valid targeting x7, with data 0xAAAA0000 and 0x5555FFFF.
  - Source 0 is granted first, then source 1.
  - The final read of x7 is 0x5555FFFF.
- **Reset mid-write**: grant source 0 (x9=0x1) then assert `rst_n`=0 at the next edge → `wr_en`=0 after that edge, x9 is unchanged, and `rr_ptr`=0.
